// File: rtl/ctrl_recovery_pkg.sv
// Shared types and helpers for the branch-mispredict recovery sequencer.
package ctrl_recovery_pkg;

    // Recovery sequencer states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2,
        DRAIN    = 2'd3
    } rec_state_t;

    // Bit positions inside the control-result flag byte
    localparam int FLAG_MISPREDICT = 0;
    localparam int FLAG_EXECUTED   = 7;

    // Drain counter width; covers DRAIN_CYCLES up to 15
    localparam int CNT_W = 4;

    // Distance of an active-list index from the head, modulo 2^width.
    // A smaller distance means an older instruction.
    function automatic logic [31:0] rel_age(input logic [31:0] x,
                                            input logic [31:0] head,
                                            input int          width);
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (x - head) & mask;
    endfunction

endpackage

// File: rtl/al_age_older.sv
// Wrap-aware active-list age compare: is index a older than index b,
// measured relative to the current active-list head.
module al_age_older
    import ctrl_recovery_pkg::*;
#(
    parameter int SIZE_AL = 7
) (
    input  logic [SIZE_AL-1:0] i_a,
    input  logic [SIZE_AL-1:0] i_b,
    input  logic [SIZE_AL-1:0] i_head,
    output logic               o_a_older
);

    logic [31:0] w_rel_a;
    logic [31:0] w_rel_b;

    assign w_rel_a   = rel_age(32'(i_a), 32'(i_head), SIZE_AL);
    assign w_rel_b   = rel_age(32'(i_b), 32'(i_head), SIZE_AL);
    assign o_a_older = (w_rel_a < w_rel_b);

endmodule

// File: rtl/ctrl_recovery_seq.sv
// Branch-mispredict recovery sequencer: holds the oldest outstanding
// mispredict and walks it through squash, fetch redirect and a drain window,
// stalling control-pipe issue throughout. Older mispredicts preempt.
module ctrl_recovery_seq
    import ctrl_recovery_pkg::*;
#(
    parameter int SIZE_PC      = 32,
    parameter int SIZE_AL      = 7,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ctrlValid_i,
    input  logic [7:0]         ctrlFlags_i,
    input  logic [SIZE_PC-1:0] ctrlNextPC_i,
    input  logic [SIZE_AL-1:0] ctrlAge_i,
    input  logic [SIZE_AL-1:0] alHead_i,
    output logic               flushValid_o,
    output logic [SIZE_AL-1:0] flushAge_o,
    output logic               redirectValid_o,
    output logic [SIZE_PC-1:0] redirectPC_o,
    input  logic               redirectReady_i,
    output logic               stallIssue_o,
    output logic               recoveryDone_o,
    output logic               busy_o
);

    // Value loaded on the redirect handshake; reaching zero ends the drain
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    rec_state_t          r_state_reg;
    rec_state_t          w_state_next;
    logic [CNT_W-1:0]    r_cnt_reg;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [SIZE_PC-1:0]  r_pend_pc_reg;
    logic [SIZE_AL-1:0]  r_pend_age_reg;

    logic                w_candidate;
    logic                w_cand_older;
    logic                w_preempt;
    logic                w_capture;
    logic                w_unused_flags;

    // Only executed mispredicts matter; the remaining flag bits are ignored
    assign w_candidate    = ctrlValid_i & ctrlFlags_i[FLAG_EXECUTED]
                                        & ctrlFlags_i[FLAG_MISPREDICT];
    assign w_unused_flags = ^ctrlFlags_i[6:1];

    al_age_older #(
        .SIZE_AL (SIZE_AL)
    ) u_age_cmp (
        .i_a       (ctrlAge_i),
        .i_b       (r_pend_age_reg),
        .i_head    (alHead_i),
        .o_a_older (w_cand_older)
    );

    // A strictly older mispredict restarts recovery from any busy state
    assign w_preempt = w_candidate & w_cand_older & (r_state_reg != IDLE);

    // State register and drain counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state_reg <= IDLE;
            r_cnt_reg   <= '0;
        end else begin
            r_state_reg <= w_state_next;
            r_cnt_reg   <= w_cnt_next;
        end
    end

    // Pending mispredict entry, reloaded on every accepted candidate
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_pc_reg  <= '0;
            r_pend_age_reg <= '0;
        end else if (w_capture) begin
            r_pend_pc_reg  <= ctrlNextPC_i;
            r_pend_age_reg <= ctrlAge_i;
        end
    end

    // Next-state logic; preemption overrides every normal transition,
    // including a redirect handshake in the same cycle (now stale)
    always_comb begin
        w_state_next = r_state_reg;
        w_cnt_next   = r_cnt_reg;
        w_capture    = 1'b0;

        case (r_state_reg)
            IDLE: begin
                if (w_candidate) begin
                    w_state_next = FLUSH;
                    w_capture    = 1'b1;
                end
            end
            FLUSH: begin
                w_state_next = REDIRECT;
            end
            REDIRECT: begin
                if (redirectReady_i) begin
                    w_state_next = DRAIN;
                    w_cnt_next   = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (r_cnt_reg == '0) begin
                    w_state_next = IDLE;
                end else begin
                    w_cnt_next = r_cnt_reg - 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (w_preempt) begin
            w_state_next = FLUSH;
            w_cnt_next   = '0;
            w_capture    = 1'b1;
        end
    end

    assign flushValid_o    = (r_state_reg == FLUSH);
    assign redirectValid_o = (r_state_reg == REDIRECT);
    assign busy_o          = (r_state_reg != IDLE);
    assign stallIssue_o    = busy_o;
    assign recoveryDone_o  = (r_state_reg == DRAIN) & (r_cnt_reg == '0) & ~w_preempt;
    assign flushAge_o      = r_pend_age_reg;
    assign redirectPC_o    = r_pend_pc_reg;

endmodule

// File: tb/tb_ctrl_recovery_seq.sv
// Self-checking bench for ctrl_recovery_seq: a directed vector table,
// hand-written corner sequences, and randomized traffic against a
// timeline-based reference model.
module tb_ctrl_recovery_seq;

    localparam int SIZE_PC = 32;
    localparam int SIZE_AL = 7;
    localparam int D       = 3;
    localparam int AL_MOD  = 128;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               ctrlValid_i;
    logic [7:0]         ctrlFlags_i;
    logic [SIZE_PC-1:0] ctrlNextPC_i;
    logic [SIZE_AL-1:0] ctrlAge_i;
    logic [SIZE_AL-1:0] alHead_i;
    logic               flushValid_o;
    logic [SIZE_AL-1:0] flushAge_o;
    logic               redirectValid_o;
    logic [SIZE_PC-1:0] redirectPC_o;
    logic               redirectReady_i;
    logic               stallIssue_o;
    logic               recoveryDone_o;
    logic               busy_o;

    always #5 clk = ~clk;

    ctrl_recovery_seq #(
        .SIZE_PC      (SIZE_PC),
        .SIZE_AL      (SIZE_AL),
        .DRAIN_CYCLES (D)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .ctrlValid_i     (ctrlValid_i),
        .ctrlFlags_i     (ctrlFlags_i),
        .ctrlNextPC_i    (ctrlNextPC_i),
        .ctrlAge_i       (ctrlAge_i),
        .alHead_i        (alHead_i),
        .flushValid_o    (flushValid_o),
        .flushAge_o      (flushAge_o),
        .redirectValid_o (redirectValid_o),
        .redirectPC_o    (redirectPC_o),
        .redirectReady_i (redirectReady_i),
        .stallIssue_o    (stallIssue_o),
        .recoveryDone_o  (recoveryDone_o),
        .busy_o          (busy_o)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model (timeline view) ----------------
    // A recovery is "active" from capture; flush is the cycle right after
    // capture, redirect follows until the handshake, and the done pulse
    // lands D cycles after the handshake.
    bit          m_active;
    bit          m_hs;
    int          m_since_cap;
    int          m_since_hs;
    logic [31:0] m_pc;
    int          m_age;

    // samples of the most recent step, for explicit scenario checks
    logic        s_flush, s_redir, s_busy;
    logic [6:0]  s_fage;
    logic [31:0] s_pc;

    function automatic int rel(input int x, input int head);
        return (((x - head) % AL_MOD) + AL_MOD) % AL_MOD;
    endfunction

    function automatic bit m_cand();
        return ctrlValid_i && ctrlFlags_i[7] && ctrlFlags_i[0];
    endfunction

    function automatic bit m_preempt();
        return m_active && m_cand() &&
               (rel(int'(ctrlAge_i), int'(alHead_i)) < rel(m_age, int'(alHead_i)));
    endfunction

    task automatic model_reset();
        m_active = 0; m_hs = 0; m_since_cap = 0; m_since_hs = 0;
        m_pc = '0; m_age = 0;
    endtask

    task automatic model_edge();
        bit pre;
        bit cand;
        pre  = m_preempt();
        cand = m_cand();
        if (pre || (!m_active && cand)) begin
            m_active = 1; m_hs = 0; m_since_cap = 0; m_since_hs = 0;
            m_pc = ctrlNextPC_i; m_age = int'(ctrlAge_i);
        end else if (m_active) begin
            if (!m_hs) begin
                if (m_since_cap >= 1 && redirectReady_i) begin
                    m_hs = 1; m_since_hs = 1;
                end else begin
                    m_since_cap++;
                end
            end else if (m_since_hs == D) begin
                m_active = 0;
            end else begin
                m_since_hs++;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic compare_model(input string tag);
        logic e_flush, e_redir, e_done;
        e_flush = m_active && !m_hs && (m_since_cap == 0);
        e_redir = m_active && !m_hs && (m_since_cap >= 1);
        e_done  = m_active && m_hs && (m_since_hs == D) && !m_preempt();
        check({"flush ", tag},    32'(flushValid_o),    32'(e_flush));
        check({"flushAge ", tag}, 32'(flushAge_o),      32'(m_age));
        check({"redir ", tag},    32'(redirectValid_o), 32'(e_redir));
        check({"redirPC ", tag},  32'(redirectPC_o),    m_pc);
        check({"stall ", tag},    32'(stallIssue_o),    32'(m_active));
        check({"busy ", tag},     32'(busy_o),          32'(m_active));
        check({"done ", tag},     32'(recoveryDone_o),  32'(e_done));
    endtask

    task automatic drive(input logic v, input logic [7:0] f, input logic [31:0] pc,
                         input logic [6:0] age, input logic [6:0] head, input logic rdy);
        ctrlValid_i     = v;
        ctrlFlags_i     = f;
        ctrlNextPC_i    = pc;
        ctrlAge_i       = age;
        alHead_i        = head;
        redirectReady_i = rdy;
    endtask

    // One cycle: sample mid-cycle, compare with model, advance on the edge
    task automatic step(input string tag);
        #4;
        compare_model(tag);
        s_flush = flushValid_o; s_redir = redirectValid_o; s_busy = busy_o;
        s_fage  = flushAge_o;   s_pc    = redirectPC_o;
        $display("[%0t] %s v=%0b f=%02h age=%0d head=%0d rdy=%0b | flush=%0b fage=%0d redir=%0b pc=%08h stall=%0b done=%0b",
                 $time, tag, ctrlValid_i, ctrlFlags_i, ctrlAge_i, alHead_i, redirectReady_i,
                 flushValid_o, flushAge_o, redirectValid_o, redirectPC_o, stallIssue_o, recoveryDone_o);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic settle(input string tag);
        for (int i = 0; i < 50 && m_active; i++) begin
            drive(1'b0, 8'h00, 32'h0, 7'd0, alHead_i, 1'b1);
            step(tag);
        end
        check({"settle ", tag}, 32'(busy_o), 32'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        v;
        logic [7:0]  flags;
        logic [31:0] pc;
        logic [6:0]  age;
        logic [6:0]  head;
        logic        rdy;
        logic        e_flush;
        logic [6:0]  e_fage;
        logic        e_redir;
        logic [31:0] e_pc;
        logic        e_stall;
        logic        e_done;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int redir_cnt;

        // single mispredict, age 5, head 0, ready high
        tbl[0] = '{1'b1, 8'h81, 32'h0040_0100, 7'd5, 7'd0, 1'b1, 1'b0, 7'd0, 1'b0, 32'h0,         1'b0, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 32'h0,         7'd0, 7'd0, 1'b1, 1'b1, 7'd5, 1'b0, 32'h0040_0100, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 32'h0,         7'd0, 7'd0, 1'b1, 1'b0, 7'd5, 1'b1, 32'h0040_0100, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 32'h0,         7'd0, 7'd0, 1'b1, 1'b0, 7'd5, 1'b0, 32'h0040_0100, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 32'h0,         7'd0, 7'd0, 1'b1, 1'b0, 7'd5, 1'b0, 32'h0040_0100, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 32'h0,         7'd0, 7'd0, 1'b1, 1'b0, 7'd5, 1'b0, 32'h0040_0100, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 32'h0,         7'd0, 7'd0, 1'b1, 1'b0, 7'd5, 1'b0, 32'h0040_0100, 1'b0, 1'b0};

        reset_n = 1'b0;
        drive(1'b0, 8'h00, 32'h0, 7'd0, 7'd0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset flush",  32'(flushValid_o),    32'd0);
        check("reset redir",  32'(redirectValid_o), 32'd0);
        check("reset stall",  32'(stallIssue_o),    32'd0);
        check("reset done",   32'(recoveryDone_o),  32'd0);
        check("reset busy",   32'(busy_o),          32'd0);
        check("reset fage",   32'(flushAge_o),      32'd0);
        check("reset pc",     32'(redirectPC_o),    32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].v, tbl[i].flags, tbl[i].pc, tbl[i].age, tbl[i].head, tbl[i].rdy);
            #4;
            check($sformatf("tbl%0d flush", i), 32'(flushValid_o),    32'(tbl[i].e_flush));
            check($sformatf("tbl%0d fage", i),  32'(flushAge_o),      32'(tbl[i].e_fage));
            check($sformatf("tbl%0d redir", i), 32'(redirectValid_o), 32'(tbl[i].e_redir));
            check($sformatf("tbl%0d pc", i),    32'(redirectPC_o),    tbl[i].e_pc);
            check($sformatf("tbl%0d stall", i), 32'(stallIssue_o),    32'(tbl[i].e_stall));
            check($sformatf("tbl%0d busy", i),  32'(busy_o),          32'(tbl[i].e_stall));
            check($sformatf("tbl%0d done", i),  32'(recoveryDone_o),  32'(tbl[i].e_done));
            $display("[%0t] tbl%0d flush=%0b fage=%0d redir=%0b pc=%08h stall=%0b done=%0b",
                     $time, i, flushValid_o, flushAge_o, redirectValid_o, redirectPC_o,
                     stallIssue_o, recoveryDone_o);
            @(posedge clk);
            model_edge();
            #1;
        end

        // ready withheld for 4 redirect cycles
        redir_cnt = 0;
        drive(1'b1, 8'h81, 32'h1000_0040, 7'd7, 7'd0, 1'b0); step("rw_cap");
        drive(1'b0, 8'h00, 32'h0, 7'd0, 7'd0, 1'b0);          step("rw_flush");
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 32'h0, 7'd0, 7'd0, 1'b0);
            step("rw_wait");
            redir_cnt += int'(s_redir);
        end
        drive(1'b0, 8'h00, 32'h0, 7'd0, 7'd0, 1'b1); step("rw_hs");
        redir_cnt += int'(s_redir);
        check("rw redirect cycles", 32'(redir_cnt), 32'd5);
        check("rw redirect pc", s_pc, 32'h1000_0040);
        settle("rw_drain");

        // preemption in REDIRECT with a same-cycle (stale) handshake
        drive(1'b1, 8'h81, 32'hAAAA_0000, 7'd20, 7'd0, 1'b0); step("pre_cap20");
        drive(1'b0, 8'h00, 32'h0, 7'd0, 7'd0, 1'b0);          step("pre_flush");
        drive(1'b1, 8'h81, 32'hBBBB_0000, 7'd10, 7'd0, 1'b1); step("pre_age10");
        drive(1'b0, 8'h00, 32'h0, 7'd0, 7'd0, 1'b0);          step("pre_reflush");
        check("pre reflush", 32'(s_flush), 32'd1);
        check("pre reflush age", 32'(s_fage), 32'd10);
        check("pre reflush pc", s_pc, 32'hBBBB_0000);
        drive(1'b1, 8'h81, 32'hCCCC_0000, 7'd30, 7'd0, 1'b0); step("pre_age30");
        drive(1'b0, 8'h00, 32'h0, 7'd0, 7'd0, 1'b0);          step("pre_after30");
        check("pre age30 dropped", 32'(s_fage), 32'd10);
        check("pre age30 no flush", 32'(s_flush), 32'd0);
        settle("pre_drain");

        // wrap-around: head 120
        drive(1'b1, 8'h81, 32'h0000_2222, 7'd2, 7'd120, 1'b0);   step("wr_cap2");
        drive(1'b1, 8'h81, 32'h0000_5555, 7'd5, 7'd120, 1'b0);   step("wr_age5");
        drive(1'b0, 8'h00, 32'h0, 7'd0, 7'd120, 1'b0);           step("wr_redir");
        check("wr age5 dropped", 32'(s_fage), 32'd2);
        check("wr age5 no flush", 32'(s_flush), 32'd0);
        drive(1'b1, 8'h81, 32'h0000_7D7D, 7'd125, 7'd120, 1'b0); step("wr_age125");
        drive(1'b0, 8'h00, 32'h0, 7'd0, 7'd120, 1'b0);           step("wr_reflush");
        check("wr preempt flush", 32'(s_flush), 32'd1);
        check("wr preempt age", 32'(s_fage), 32'd125);
        settle("wr_drain");

        // asynchronous reset in the middle of DRAIN
        drive(1'b1, 8'h81, 32'h0000_3333, 7'd9, 7'd0, 1'b1); step("ar_cap");
        drive(1'b0, 8'h00, 32'h0, 7'd0, 7'd0, 1'b1);
        step("ar_flush");
        step("ar_redir");
        step("ar_drain");
        #2;
        reset_n = 1'b0;
        #1;
        check("ar flush",  32'(flushValid_o),    32'd0);
        check("ar redir",  32'(redirectValid_o), 32'd0);
        check("ar stall",  32'(stallIssue_o),    32'd0);
        check("ar done",   32'(recoveryDone_o),  32'd0);
        check("ar busy",   32'(busy_o),          32'd0);
        check("ar fage",   32'(flushAge_o),      32'd0);
        check("ar pc",     32'(redirectPC_o),    32'd0);
        $display("[%0t] ar reset asserted mid-drain busy=%0b", $time, busy_o);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // non-candidates in IDLE are ignored
        drive(1'b1, 8'h80, 32'h0000_9999, 7'd3, 7'd0, 1'b1); step("nc_noflag0");
        check("nc noflag0 busy", 32'(s_busy), 32'd0);
        drive(1'b1, 8'h01, 32'h0000_9999, 7'd3, 7'd0, 1'b1); step("nc_noexec");
        check("nc noexec busy", 32'(s_busy), 32'd0);
        drive(1'b0, 8'h81, 32'h0000_9999, 7'd3, 7'd0, 1'b1); step("nc_novalid");
        check("nc novalid busy", 32'(s_busy), 32'd0);
        drive(1'b0, 8'h00, 32'h0, 7'd0, 7'd0, 1'b1);         step("nc_idle");
        check("nc idle busy", 32'(s_busy), 32'd0);
        check("nc idle fage", 32'(s_fage), 32'd0);

        // fresh recovery after reset
        drive(1'b1, 8'h81, 32'h0000_4444, 7'd4, 7'd0, 1'b1); step("ar_new");
        drive(1'b0, 8'h00, 32'h0, 7'd0, 7'd0, 1'b1);         step("ar_newflush");
        check("ar new flush", 32'(s_flush), 32'd1);
        check("ar new age", 32'(s_fage), 32'd4);
        settle("ar_newdrain");

        // randomized traffic against the model
        begin
            logic [6:0] head;
            logic [7:0] flag_set [6];
            head = 7'd0;
            flag_set[0] = 8'h81; flag_set[1] = 8'h80; flag_set[2] = 8'h01;
            flag_set[3] = 8'hFF; flag_set[4] = 8'h83; flag_set[5] = 8'h00;
            for (int i = 0; i < 800; i++) begin
                head = head + 7'($urandom_range(0, 2));
                drive(($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0,
                      flag_set[$urandom_range(0, 5)],
                      $urandom(),
                      7'($urandom_range(0, 127)),
                      head,
                      ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0);
                step($sformatf("rnd%0d", i));
            end
            settle("rnd_drain");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_recovery_seq.md
# ctrl_recovery_seq

Sequencer that sits behind the control-execution pipe and drives branch-mispredict recovery. It consumes resolved control results (flags, next PC, active-list age) and keeps the single oldest outstanding mispredict. It sequences a one-cycle squash broadcast, a redirect handshake to fetch, and a fixed drain window, and stalls control-pipe issue for the whole recovery. An older mispredict arriving mid-recovery preempts the current one.

## Interface
Parameters:
- SIZE_PC, 32, PC width
- SIZE_AL, 7, active-list index/age width
- DRAIN_CYCLES, 3, post-redirect drain length; legal range 1..15

Ports:
- clk  in  1  sole clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ctrlValid_i  in  1  control result valid this cycle
- ctrlFlags_i  in  8  execution flags of the control result; bit0 = mispredict, bit7 = executed
- ctrlNextPC_i  in  SIZE_PC  resolved next PC
- ctrlAge_i  in  SIZE_AL  active-list index of the resolved instruction
- alHead_i  in  SIZE_AL  active-list head; the age reference
- flushValid_o  out  1  squash broadcast, one cycle
- flushAge_o  out  SIZE_AL  squash everything younger than this index
- redirectValid_o  out  1  fetch redirect request
- redirectPC_o  out  SIZE_PC  redirect target
- redirectReady_i  in  1  fetch accepts redirect
- stallIssue_o  out  1  block control-pipe issue
- recoveryDone_o  out  1  one-cycle completion pulse
- busy_o  out  1  state != IDLE

## Operation
- Candidate: ctrlValid_i & ctrlFlags_i[7] & ctrlFlags_i[0]. All other results are ignored.
- Relative age: rel(x) = (x − alHead_i) mod 2^SIZE_AL. "a older than b" means rel(a) < rel(b).
- Held entry: registers pendPC and pendAge.
- States:
  - IDLE → FLUSH on a candidate, capturing the candidate into pendPC/pendAge.
  - FLUSH (one cycle) → REDIRECT.
  - REDIRECT holds until redirectValid_o & redirectReady_i, then → DRAIN with cnt = DRAIN_CYCLES−1.
  - DRAIN decrements cnt. At cnt == 0 → IDLE.
- Preemption: in FLUSH, REDIRECT or DRAIN, a candidate older than pendAge recaptures the entry and forces → FLUSH. Preemption overrides every other transition, including a REDIRECT handshake completing in the same cycle (that redirect is considered stale) and the last DRAIN cycle.
- A candidate equal to or younger than pendAge is dropped.
- Outputs are decoded from the state registers:
  - flushValid_o = FLUSH
  - redirectValid_o = REDIRECT
  - stallIssue_o = busy_o = (state != IDLE)
  - recoveryDone_o = DRAIN & cnt == 0 & no preemption
- flushAge_o and redirectPC_o always present pendAge and pendPC.

## Timing
- Reset (asynchronous, any state): state = IDLE, cnt = 0, pendPC = 0, pendAge = 0. All outputs 0.
- Candidate sampled at edge t: flushValid_o is high in cycle t+1 and redirectValid_o rises in cycle t+2.
- redirectValid_o and redirectPC_o stay stable until the handshake. Ready without valid has no effect.
- Handshake at edge h: DRAIN occupies cycles h+1 … h+DRAIN_CYCLES. recoveryDone_o is high in cycle h+DRAIN_CYCLES. IDLE starts at h+DRAIN_CYCLES+1.
- Minimum recovery with ready tied high: 2 + DRAIN_CYCLES cycles of stallIssue_o.
- A new candidate in the first IDLE cycle after done starts a fresh recovery; there are no dead cycles.
- Age wrap-around is handled purely through rel(); the head may move during recovery.

## Structure
- Shared package ctrl_recovery_pkg:
  - state enum (IDLE, FLUSH, REDIRECT, DRAIN)
  - FLAG_MISPREDICT = 0, FLAG_EXECUTED = 7
  - relative-age function
- Sub-module al_age_older: combinational wrap-aware compare (a, b, head → a_older). Instantiated once for the preemption check.
- Top: FSM, drain counter, pending registers, about 150–250 lines.

## Test plan
- Single mispredict (age 5, head 0, nextPC 0x0040_0100), ready high, DRAIN_CYCLES 3 → flush 1 cycle with flushAge_o 5, redirect 1 cycle with PC 0x0040_0100, 3 drain cycles, done pulse in last, stall for 5 cycles.
- Ready withheld 4 cycles → redirectValid_o held 4+1 cycles with PC unchanged, then drain proceeds normally.
- Preemption: age 20 in REDIRECT, then age 10 arrives (head 0) → flush reissued with age 10, redirect PC switches. Age 30 arriving later is ignored.
- Wrap: head 120, pending age 2 (rel 10), candidate age 125 (rel 5) → preempts. Candidate age 5 (rel 13) → dropped.
- Non-mispredict or non-executed results (flags bit0 = 0 or bit7 = 0) in IDLE → no state change, all outputs 0.
- reset_n low in the middle of DRAIN → all outputs 0 immediately (asynchronously). After release, the block is in IDLE and accepts a new mispredict normally.
